// File: rtl/wash_phase_timer_if.sv
// Signal bundle between the washing-machine controller and its phase timer.
// The controller (master) publishes its state code and the pause request;
// the timer (slave) returns the per-phase busy flags, the remaining time and
// the end-of-phase pulse.
`timescale 1ns/1ps

interface wash_phase_timer_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       state;
    logic             pause;
    logic             rinsing_busy;
    logic             draining_busy;
    logic             dehydrating_busy;
    logic             warning_busy;
    logic [CNT_W-1:0] remaining;
    logic             phase_done;

    modport master (
        output state,
        output pause,
        input  rinsing_busy,
        input  draining_busy,
        input  dehydrating_busy,
        input  warning_busy,
        input  remaining,
        input  phase_done
    );

    modport slave (
        input  state,
        input  pause,
        output rinsing_busy,
        output draining_busy,
        output dehydrating_busy,
        output warning_busy,
        output remaining,
        output phase_done
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Phase duration scheduler for the washing-machine controller.
// Watches the controller state code, loads a per-phase countdown whenever a
// timed phase is entered, and reports "keep running" flags, the remaining
// time for the display and a one-cycle end-of-phase pulse.
// Optional feature: define WASH_TIMER_PAUSE_EN to let 'pause' freeze the
// countdown; without it the pause signal is ignored.
`timescale 1ns/1ps

module wash_phase_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 8,
    parameter int RINSE_T  = 20,
    parameter int DRAIN_T  = 10,
    parameter int DEHYD_T  = 15,
    parameter int WARN_T   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    wash_phase_timer_if.slave       tif
);

    // Controller state codes; 101 and 111 are illegal and treated as untimed.
    typedef enum logic [2:0] {
        ST_FREE     = 3'b000,
        ST_SUPPLY   = 3'b001,
        ST_RINSING  = 3'b011,
        ST_DRAINING = 3'b010,
        ST_DEHYD    = 3'b110,
        ST_WARNING  = 3'b100
    } state_code_e;

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [2:0]       prev_q;
    logic [CNT_W-1:0] cnt;
    logic [PRE_W-1:0] pre;
    logic             phase_done_q;

    logic             entry;
    logic             timed;
    logic             hold;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] cnt_d;
    logic [PRE_W-1:0] pre_d;
    logic             done_d;

    assign entry = (tif.state != prev_q);

`ifdef WASH_TIMER_PAUSE_EN
    assign hold = tif.pause;
`else
    assign hold = 1'b0;
`endif

    // Classify the current state and pick the duration loaded on entry.
    always_comb begin
        timed = 1'b0;
        dur   = '0;
        case (tif.state)
            ST_RINSING: begin
                timed = 1'b1;
                dur   = CNT_W'(RINSE_T);
            end
            ST_DRAINING: begin
                timed = 1'b1;
                dur   = CNT_W'(DRAIN_T);
            end
            ST_DEHYD: begin
                timed = 1'b1;
                dur   = CNT_W'(DEHYD_T);
            end
            ST_WARNING: begin
                timed = 1'b1;
                dur   = CNT_W'(WARN_T);
            end
            default: begin
                timed = 1'b0;
                dur   = '0;
            end
        endcase
    end

    // Next countdown/prescaler values: entry reloads (abandoning any countdown
    // without a pulse), untimed states park at zero, otherwise tick down.
    always_comb begin
        cnt_d  = cnt;
        pre_d  = pre;
        done_d = 1'b0;
        if (entry) begin
            cnt_d = timed ? dur : '0;
            pre_d = '0;
        end else if (!timed) begin
            cnt_d = '0;
            pre_d = '0;
        end else if ((cnt != '0) && !hold) begin
            if (pre == PRE_LAST) begin
                pre_d = '0;
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    done_d = 1'b1;
                end
            end else begin
                pre_d = pre + PRE_W'(1);
            end
        end
    end

    // Timer registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q       <= ST_FREE;
            cnt          <= '0;
            pre          <= '0;
            phase_done_q <= 1'b0;
        end else begin
            prev_q       <= tif.state;
            cnt          <= cnt_d;
            pre          <= pre_d;
            phase_done_q <= done_d;
        end
    end

    // A phase stays busy during its entry cycle and while time is left.
    assign tif.rinsing_busy     = (tif.state == ST_RINSING)  && (entry || (cnt != '0));
    assign tif.draining_busy    = (tif.state == ST_DRAINING) && (entry || (cnt != '0));
    assign tif.dehydrating_busy = (tif.state == ST_DEHYD)    && (entry || (cnt != '0));
    assign tif.warning_busy     = (tif.state == ST_WARNING)  && (entry || (cnt != '0));
    assign tif.remaining        = cnt;
    assign tif.phase_done       = phase_done_q;

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Phase duration scheduler for the washing-machine controller. It watches the 3-bit controller state code and loads a per-phase countdown whenever a timed phase is entered. It returns the per-phase "keep running" flags that the state machine samples to decide when to advance. It also exports remaining time for the display and a one-cycle end-of-phase pulse for the buzzer/LED logic.

## Interface
- TICK_DIV, 50000000: clk cycles per time unit (1 s at 50 MHz); ≥2.
- CNT_W, 8: width of countdown / remaining.
- RINSE_T, 20: Rinsing duration in ticks.
- DRAIN_T, 10: Water_draining duration in ticks.
- DEHYD_T, 15: Dehydrating duration in ticks.
- WARN_T, 5: Warning duration in ticks. All durations are < 2^CNT_W.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- state  in  3  controller state code: Free 000, Water_supply 001, Rinsing 011, Water_draining 010, Dehydrating 110, Warning 100.
- pause  in  1  freeze countdown (active only with WASH_TIMER_PAUSE_EN).
- rinsing_busy  out  1  1 = stay in Rinsing.
- draining_busy  out  1  1 = stay in Water_draining.
- dehydrating_busy  out  1  1 = stay in Dehydrating.
- warning_busy  out  1  1 = stay in Warning.
- remaining  out  CNT_W  ticks left in current timed phase, 0 otherwise.
- phase_done  out  1  registered one-cycle pulse when a countdown expires.

## Operation
- Registers:
  - prev_q: 3 bits, reset 000.
  - cnt: CNT_W bits, reset 0.
  - pre: prescaler 0..TICK_DIV-1, reset 0.
  - phase_done: reset 0.
- entry = (state != prev_q), combinational. prev_q <= state every cycle.
- Timed phases: 011, 010, 110, 100. Untimed: 000, 001, and illegal codes 101, 111.
- On a clock edge with entry=1:
  - timed state: cnt <= duration of that phase, pre <= 0.
  - untimed state: cnt <= 0, pre <= 0.
  - A countdown in progress is abandoned; no phase_done is generated.
- On a clock edge with entry=0, timed state, cnt != 0:
  - pre increments.
  - When pre == TICK_DIV-1: pre <= 0, cnt <= cnt-1.
  - If cnt was 1, phase_done <= 1 for one cycle.
- With cnt == 0 and no entry: pre and cnt hold. In untimed states, cnt and pre are held at 0.
- Busy outputs are combinational: X_busy = (state == X) && (entry || cnt != 0). At most one busy output is high at any time. All busy outputs are 0 in untimed states.
- remaining = cnt.
- Reset mid-phase:
  - All registers clear immediately.
  - Busy outputs follow the formula above: if state is already 000, all are 0.
- Duration 0: busy is high only during the entry cycle; the phase lasts 1 cycle.

## Timing
- Entry edge E0 is the edge at which state changes to a timed phase.
  - Busy is high from E0 through the cycle ending at edge E0 + 1 + DUR·TICK_DIV.
  - That is DUR·TICK_DIV+1 cycles.
- cnt is loaded at E0+1 and decrements at E0+1+k·TICK_DIV for k = 1..DUR.
- phase_done is high in the cycle after the final decrement, coincident with the first busy-low cycle.
- The controller leaves the phase on the edge that ends the first busy-low cycle.
- Outputs after reset: all busy = 0 (state 000), remaining = 0, phase_done = 0.

## Configuration
- WASH_TIMER_PAUSE_EN defined:
  - pause=1 holds pre and cnt and suppresses phase_done.
  - Busy remains high while cnt != 0.
  - entry loading still takes priority over pause.
- Not defined: the pause port exists but is ignored (no logic).

## Test plan
- Setup for all scenarios: TICK_DIV=4, RINSE_T=3, DRAIN_T=2, DEHYD_T=1, WARN_T=0.
- Reset, state=000 -> all busy 0, remaining 0, phase_done 0.
- state 001→011 at E0 -> rinsing_busy high for 13 cycles, then:
  - remaining 3,2,1,0 with changes at E0+5, +9, +13;
  - phase_done high for one cycle after E0+13.
- Full sequence 011→010→110→100 driven when each busy drops -> busy windows of 13, 9, 5 and 1 cycles respectively.
- Mid-Rinsing (remaining=2), state→000 -> rinsing_busy 0 immediately, remaining 0 next cycle, no phase_done.
- Mid-Draining, rst pulsed low while state=010 -> remaining 0 asynchronously; after release, draining_busy re-asserts (entry 000→010) and a fresh 9-cycle window starts.
- Macro on, Rinsing, pause=1 for 10 cycles after first decrement -> remaining holds 2, busy stays high, window extends to 23 cycles.
